id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
- Parametrised next-generation decode stage of the ARM-subset 5-stage pipeline.
- Integrates decoder, condition check, register file with write-through bypass, hazard detection, and the ID/EX pipeline register with flush, freeze and bubble insertion.
- Sits between IF/ID register and EXE stage; `hazard` output freezes PC and IF/ID register.

Parameters:
- DATA_W, 32: register and operand width.
- PC_W, 32: program counter width.
- NREG, 15: implemented registers R0..R(NREG-1), legal range 2..16. Reads of higher indices return 0; writes to them are ignored.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  branch taken in EXE; next ID/EX load is a bubble.
- freeze  in  1  downstream stall; ID/EX register holds.
- pc_in  in  PC_W  PC of the instruction in ID.
- instr  in  32  instruction in ID.
- status_in  in  4  NZCV flags from status register.
- wb_en_in  in  1  writeback enable.
- wb_dest  in  4  writeback register index.
- wb_value  in  DATA_W  writeback data.
- exe_wb_en  in  1  EXE-stage writeback enable, for hazard checks.
- exe_dest  in  4  EXE-stage destination register.
- exe_mem_read  in  1  EXE-stage instruction is a load.
- mem_wb_en  in  1  MEM-stage writeback enable.
- mem_dest  in  4  MEM-stage destination register.
- hazard  out  1  combinational stall request to IF.
- wb_en, mem_r_en, mem_w_en, b_en, s_out  out  1 each  registered controls.
- exec_cmd  out  4  registered ALU command.
- pc_out  out  PC_W  registered PC.
- val_rn, val_rm  out  DATA_W  registered operands.
- imm  out  1  registered immediate flag.
- shift_operand  out  12  registered shift operand.
- simm24  out  24  registered branch offset.
- dest  out  4  registered destination register.
- status_out  out  4  registered flags.
- src1, src2  out  4  registered source register indices.

Behaviour:
- Field decode:
  - cond = [31:28]; mode = [27:26]; I = [25]; opcode = [24:21]; S/L = [20]; Rn = [19:16]; Rd = [15:12]; Rm = [3:0]; shift_operand = [11:0]; simm24 = [23:0].
- Mode 00, data processing; exec_cmd by opcode:
  - MOV 1101→0001; MVN 1111→1001; ADD 0100→0010; ADC 0101→0011.
  - SUB 0010→0100; SBC 0110→0101; AND 0000→0110; ORR 1100→0111.
  - EOR 0001→1000; CMP 1010→0100; TST 1000→0110.
  - Unlisted opcode → all enables 0 (NOP).
  - wb_en = 1 except CMP/TST; s_out = S.
- Mode 01, memory: exec_cmd = 0010. L=1 is LDR (mem_r_en = 1, wb_en = 1). L=0 is STR (mem_w_en = 1). s_out = 0.
- Mode 10, branch: b_en = 1; all other enables 0.
- Mode 11: NOP.
- Condition check against status_in, ARM encodings 0000..1110 (EQ..AL); 1111 = never.
  - On failure, all control enables are forced to 0.
  - Data fields still load.
- Register file:
  - NREG x DATA_W, written at posedge when wb_en_in.
  - Same-cycle read of wb_dest returns wb_value (combinational bypass).
  - Reset clears all registers to 0.
- Sources:
  - src1 = Rn; it is used unless MOV/MVN or branch.
  - src2 = Rd for STR; Rm for mode 00 with I=0; otherwise unused.
  - val_rm reads src2.
- Hazard, without FWD_EN: a used source equals exe_dest with exe_wb_en, or mem_dest with mem_wb_en.
- ID/EX register update priority: rst > freeze (hold all) > flush or hazard (bubble) > load.
  - A bubble zeroes wb_en, mem_r_en, mem_w_en, b_en and s_out; data fields are don't-care, implemented as load.
- Reset value of every output register is 0.
- Reset mid-operation clears the pipeline register and the register file asynchronously.
- Latency: 1 cycle from instr to registered outputs.
- `hazard` is gated to 0 while flush = 1.

Optional Feature:
- FWD_EN defined:
  - hazard asserts only on load-use, i.e. exe_mem_read with exe_wb_en and a used source equal to exe_dest.
  - src1/src2 feed the external forwarding unit.
- FWD_EN undefined:
  - full hazard rule as above.
  - src1/src2 are still registered but unused downstream.

Decomposition:
- Package id_pkg holds:
  - mode constants MODE_DP/MODE_MEM/MODE_BR;
  - opcode and exec_cmd localparams;
  - condition code constants;
  - NOP control bundle.
- Natural sub-module: id_regfile (NREG, DATA_W; async reset, write-through bypass).
- Decoder, condition check and pipeline register remain in id_stage_pipe.

Test Plan:
- Write R3=0x0000_0005 via wb_en_in, same cycle decode ADD R1,R3,R3 (0xE083_1003) → next cycle val_rn = val_rm = 5, exec_cmd = 0010, wb_en = 1.
- Without FWD_EN: exe_dest = 3, exe_wb_en = 1, instr = ADD R1,R3,R2 → hazard = 1, next ID/EX has all enables 0. Repeat with exe_dest = 4 → hazard = 0.
- With FWD_EN: same as previous with exe_mem_read = 0 → hazard = 0. Set exe_mem_read = 1 → hazard = 1 and a bubble is inserted.
- Condition fail: status_in = 0100 (Z=1), instr ADDNE (cond 0001) → registered wb_en = 0; status_in = 0000 → wb_en = 1.
- Control priority:
  - freeze = 1 together with flush = 1 → outputs unchanged for the cycle.
  - freeze = 0, flush = 1 → bubble, with pc_out updated.
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; subsequent read of R3 returns 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants, control bundle and condition evaluation for the ID stage.
package id_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned CMD_W     = 4;
  localparam int unsigned NZCV_W    = 4;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b_en;
    logic             s_out;
    logic [CMD_W-1:0] exec_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Flags are packed {N, Z, C, V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [NZCV_W-1:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG x DATA_W register file, two read ports with same-cycle write-through bypass.
module id_regfile
  import id_pkg::*;
#(
  parameter int unsigned NREG   = 15,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [REG_IDX_W-1:0] raddr1_i,
  input  logic [REG_IDX_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]    rdata1_o,
  output logic [DATA_W-1:0]    rdata2_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Indices at or above NREG never match, so their writes drop and reads return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (waddr_i == REG_IDX_W'(i)) regs_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (raddr1_i == REG_IDX_W'(i))
        rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[i];
      if (raddr2_i == REG_IDX_W'(i))
        rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[i];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// ARM-subset decode stage: decoder, condition check, register file, hazard unit, ID/EX register.
// Define FWD_EN to restrict stalls to load-use hazards when an external forwarding unit exists.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned NREG   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 freeze,
  input  logic [PC_W-1:0]      pc_in,
  input  logic [INSTR_W-1:0]   instr,
  input  logic [NZCV_W-1:0]    status_in,
  input  logic                 wb_en_in,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]    wb_value,
  input  logic                 exe_wb_en,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_mem_read,
  input  logic                 mem_wb_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  output logic                 hazard,
  output logic                 wb_en,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 b_en,
  output logic                 s_out,
  output logic [CMD_W-1:0]     exec_cmd,
  output logic [PC_W-1:0]      pc_out,
  output logic [DATA_W-1:0]    val_rn,
  output logic [DATA_W-1:0]    val_rm,
  output logic                 imm,
  output logic [11:0]          shift_operand,
  output logic [23:0]          simm24,
  output logic [REG_IDX_W-1:0] dest,
  output logic [NZCV_W-1:0]    status_out,
  output logic [REG_IDX_W-1:0] src1,
  output logic [REG_IDX_W-1:0] src2
);

  logic [3:0]           cond;
  logic [1:0]           mode;
  logic                 i_bit;
  logic [3:0]           opcode;
  logic                 s_bit;
  logic [REG_IDX_W-1:0] rn, rd, rm;

  assign cond   = instr[31:28];
  assign mode   = instr[27:26];
  assign i_bit  = instr[25];
  assign opcode = instr[24:21];
  assign s_bit  = instr[20];
  assign rn     = instr[19:16];
  assign rd     = instr[15:12];
  assign rm     = instr[3:0];

  ctrl_t ctrl_dec;

  always_comb begin
    ctrl_dec = CTRL_NOP;
    case (mode)
      MODE_DP: begin
        ctrl_dec.wb_en = 1'b1;
        ctrl_dec.s_out = s_bit;
        case (opcode)
          OP_MOV:  ctrl_dec.exec_cmd = CMD_MOV;
          OP_MVN:  ctrl_dec.exec_cmd = CMD_MVN;
          OP_ADD:  ctrl_dec.exec_cmd = CMD_ADD;
          OP_ADC:  ctrl_dec.exec_cmd = CMD_ADC;
          OP_SUB:  ctrl_dec.exec_cmd = CMD_SUB;
          OP_SBC:  ctrl_dec.exec_cmd = CMD_SBC;
          OP_AND:  ctrl_dec.exec_cmd = CMD_AND;
          OP_ORR:  ctrl_dec.exec_cmd = CMD_ORR;
          OP_EOR:  ctrl_dec.exec_cmd = CMD_EOR;
          OP_CMP: begin
            ctrl_dec.exec_cmd = CMD_SUB;
            ctrl_dec.wb_en    = 1'b0;
          end
          OP_TST: begin
            ctrl_dec.exec_cmd = CMD_AND;
            ctrl_dec.wb_en    = 1'b0;
          end
          default: ctrl_dec = CTRL_NOP;
        endcase
      end
      MODE_MEM: begin
        ctrl_dec.exec_cmd = CMD_ADD;
        ctrl_dec.mem_r_en = s_bit;
        ctrl_dec.wb_en    = s_bit;
        ctrl_dec.mem_w_en = !s_bit;
      end
      MODE_BR: ctrl_dec.b_en = 1'b1;
      default: ctrl_dec = CTRL_NOP;
    endcase
    // A failed condition kills side effects but the data fields still travel.
    if (!cond_pass(cond, status_in)) begin
      ctrl_dec.wb_en    = 1'b0;
      ctrl_dec.mem_r_en = 1'b0;
      ctrl_dec.mem_w_en = 1'b0;
      ctrl_dec.b_en     = 1'b0;
      ctrl_dec.s_out    = 1'b0;
    end
  end

  logic                 is_mov, is_str, use_src1, use_src2;
  logic [REG_IDX_W-1:0] src2_sel;

  assign is_mov   = (mode == MODE_DP) && (opcode == OP_MOV || opcode == OP_MVN);
  assign is_str   = (mode == MODE_MEM) && !s_bit;
  assign use_src1 = !is_mov && (mode != MODE_BR);
  assign use_src2 = is_str || (mode == MODE_DP && !i_bit);
  assign src2_sel = is_str ? rd : rm;

  logic [DATA_W-1:0] rdata1, rdata2;

  id_regfile #(
    .NREG   (NREG),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en_in),
    .waddr_i  (wb_dest),
    .wdata_i  (wb_value),
    .raddr1_i (rn),
    .raddr2_i (src2_sel),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  logic exe_match, hazard_raw;

  assign exe_match = exe_wb_en && ((use_src1 && rn == exe_dest) ||
                                   (use_src2 && src2_sel == exe_dest));

`ifdef FWD_EN
  logic unused_mem_stage;
  assign unused_mem_stage = mem_wb_en ^ (^mem_dest);
  assign hazard_raw       = exe_mem_read && exe_match;
`else
  logic unused_exe_mem_read;
  logic mem_match;
  assign unused_exe_mem_read = exe_mem_read;
  assign mem_match  = mem_wb_en && ((use_src1 && rn == mem_dest) ||
                                    (use_src2 && src2_sel == mem_dest));
  assign hazard_raw = exe_match || mem_match;
`endif

  assign hazard = hazard_raw && !flush;

  ctrl_t                ctrl_d, ctrl_q;
  logic [PC_W-1:0]      pc_q;
  logic [DATA_W-1:0]    val_rn_q, val_rm_q;
  logic                 imm_q;
  logic [11:0]          shift_q;
  logic [23:0]          simm24_q;
  logic [REG_IDX_W-1:0] dest_q, src1_q, src2_q;
  logic [NZCV_W-1:0]    status_q;

  // Bubble: control enables dropped, data fields loaded as usual.
  always_comb begin
    ctrl_d = ctrl_dec;
    if (flush || hazard) begin
      ctrl_d.wb_en    = 1'b0;
      ctrl_d.mem_r_en = 1'b0;
      ctrl_d.mem_w_en = 1'b0;
      ctrl_d.b_en     = 1'b0;
      ctrl_d.s_out    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= CTRL_NOP;
      pc_q     <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      imm_q    <= 1'b0;
      shift_q  <= '0;
      simm24_q <= '0;
      dest_q   <= '0;
      status_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
    end else if (!freeze) begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_in;
      val_rn_q <= rdata1;
      val_rm_q <= rdata2;
      imm_q    <= i_bit;
      shift_q  <= instr[11:0];
      simm24_q <= instr[23:0];
      dest_q   <= rd;
      status_q <= status_in;
      src1_q   <= rn;
      src2_q   <= src2_sel;
    end
  end

  assign wb_en         = ctrl_q.wb_en;
  assign mem_r_en      = ctrl_q.mem_r_en;
  assign mem_w_en      = ctrl_q.mem_w_en;
  assign b_en          = ctrl_q.b_en;
  assign s_out         = ctrl_q.s_out;
  assign exec_cmd      = ctrl_q.exec_cmd;
  assign pc_out        = pc_q;
  assign val_rn        = val_rn_q;
  assign val_rm        = val_rm_q;
  assign imm           = imm_q;
  assign shift_operand = shift_q;
  assign simm24        = simm24_q;
  assign dest          = dest_q;
  assign status_out    = status_q;
  assign src1          = src1_q;
  assign src2          = src2_q;

endmodule
